// File: rtl/vga_pkg.sv
// Constants and state encoding shared by the vga framebuffer write-side blocks.
package vga_pkg;

  localparam int FB_WIDTH     = 400;
  localparam int FB_HEIGHT    = 300;
  localparam int ADDR_WIDTH   = 18;
  localparam int DATA_WIDTH   = 8;
  localparam int STRIDE_SHIFT = 9;
  localparam int COORD_WIDTH  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLIP = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } fill_state_t;

  // Linear framebuffer address of pixel (x, y) with a power-of-two row stride.
  function automatic logic [ADDR_WIDTH-1:0] pixel_addr(
    input logic [COORD_WIDTH-1:0] x,
    input logic [COORD_WIDTH-1:0] y
  );
    return (ADDR_WIDTH'(y) << STRIDE_SHIFT) + ADDR_WIDTH'(x);
  endfunction

  // Exclusive end coordinate, saturated at the framebuffer edge; the extra bit keeps the sum from wrapping.
  function automatic logic [COORD_WIDTH:0] clip_end(
    input logic [COORD_WIDTH-1:0] start,
    input logic [COORD_WIDTH-1:0] len,
    input int                     limit
  );
    logic [COORD_WIDTH:0] sum;
    sum = {1'b0, start} + {1'b0, len};
    return (sum > (COORD_WIDTH+1)'(limit)) ? (COORD_WIDTH+1)'(limit) : sum;
  endfunction

endpackage

// File: rtl/vga_out_arbiter.sv
// Priority mux and output register for the vga write port: CPU writes always win,
// fill pixels go out only on free cycles and are acknowledged through fill_accept.
module vga_out_arbiter
  import vga_pkg::*;
(
  input  logic                  clk50M,
  input  logic                  rst,
  input  logic                  cpu_write_enable,
  input  logic [ADDR_WIDTH-1:0] cpu_write_addr,
  input  logic [DATA_WIDTH-1:0] cpu_write_data,
  input  logic                  fill_valid,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [DATA_WIDTH-1:0] fill_data,
  output logic                  fill_accept,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_enable
);

  logic [ADDR_WIDTH-1:0] write_addr_r;
  logic [DATA_WIDTH-1:0] write_data_r;
  logic                  write_enable_r;

  assign fill_accept  = fill_valid & ~cpu_write_enable;
  assign write_addr   = write_addr_r;
  assign write_data   = write_data_r;
  assign write_enable = write_enable_r;

  // Output register; address and data hold when nothing is written.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      write_addr_r   <= {ADDR_WIDTH{1'b0}};
      write_data_r   <= {DATA_WIDTH{1'b0}};
      write_enable_r <= 1'b0;
    end else if (cpu_write_enable) begin
      write_addr_r   <= cpu_write_addr;
      write_data_r   <= cpu_write_data;
      write_enable_r <= 1'b1;
    end else if (fill_valid) begin
      write_addr_r   <= fill_addr;
      write_data_r   <= fill_data;
      write_enable_r <= 1'b1;
    end else begin
      write_enable_r <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: clips a command to the framebuffer and streams its pixels
// row-major into the vga write port, merged with direct CPU pixel writes.
module vga_rect_fill
  import vga_pkg::*;
(
  input  logic        clk50M,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x0,
  input  logic [9:0]  cmd_y0,
  input  logic [9:0]  cmd_w,
  input  logic [9:0]  cmd_h,
  input  logic [7:0]  cmd_color,
  input  logic        cpu_write_enable,
  input  logic [17:0] cpu_write_addr,
  input  logic [7:0]  cpu_write_data,
  output logic [17:0] write_addr,
  output logic [7:0]  write_data,
  output logic        write_enable,
  output logic        busy,
  output logic        done
);

  fill_state_t state_r, state_next_s;

  logic [COORD_WIDTH-1:0] x0_r, y0_r, w_r, h_r;
  logic [DATA_WIDTH-1:0]  color_r;
  logic [COORD_WIDTH:0]   x_end_r, y_end_r;
  logic [COORD_WIDTH-1:0] x_r, y_r;
  logic                   cmd_ready_r, busy_r, done_r;

  logic                   degenerate_s;
  logic                   row_end_s;
  logic                   last_pixel_s;
  logic                   fill_valid_s;
  logic                   fill_accept_s;
  logic [ADDR_WIDTH-1:0]  fill_addr_s;

  assign degenerate_s = (w_r == 10'd0) || (h_r == 10'd0) ||
                        (x0_r >= COORD_WIDTH'(FB_WIDTH)) ||
                        (y0_r >= COORD_WIDTH'(FB_HEIGHT));
  assign row_end_s    = (({1'b0, x_r} + 11'd1) == x_end_r);
  assign last_pixel_s = row_end_s && (({1'b0, y_r} + 11'd1) == y_end_r);
  assign fill_valid_s = (state_r == ST_FILL);
  assign fill_addr_s  = pixel_addr(x_r, y_r);

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;

  vga_out_arbiter u_out_arbiter (
    .clk50M           (clk50M),
    .rst              (rst),
    .cpu_write_enable (cpu_write_enable),
    .cpu_write_addr   (cpu_write_addr),
    .cpu_write_data   (cpu_write_data),
    .fill_valid       (fill_valid_s),
    .fill_addr        (fill_addr_s),
    .fill_data        (color_r),
    .fill_accept      (fill_accept_s),
    .write_addr       (write_addr),
    .write_data       (write_data),
    .write_enable     (write_enable)
  );

  // State register.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; the fill only advances on cycles the arbiter took its pixel.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) state_next_s = ST_CLIP;
        else           state_next_s = ST_IDLE;
      end
      ST_CLIP: begin
        if (degenerate_s) state_next_s = ST_DONE;
        else              state_next_s = ST_FILL;
      end
      ST_FILL: begin
        if (fill_accept_s && last_pixel_s) state_next_s = ST_DONE;
        else                               state_next_s = ST_FILL;
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Status outputs registered from the next state so they line up with state_r.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      cmd_ready_r <= (state_next_s == ST_IDLE);
      busy_r      <= (state_next_s != ST_IDLE);
      done_r      <= (state_next_s == ST_DONE);
    end
  end

  // Command latch, clip bounds and pixel walker.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      x0_r    <= 10'd0;
      y0_r    <= 10'd0;
      w_r     <= 10'd0;
      h_r     <= 10'd0;
      color_r <= 8'd0;
      x_end_r <= 11'd0;
      y_end_r <= 11'd0;
      x_r     <= 10'd0;
      y_r     <= 10'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            x0_r    <= cmd_x0;
            y0_r    <= cmd_y0;
            w_r     <= cmd_w;
            h_r     <= cmd_h;
            color_r <= cmd_color;
          end
        end
        ST_CLIP: begin
          x_end_r <= clip_end(x0_r, w_r, FB_WIDTH);
          y_end_r <= clip_end(y0_r, h_r, FB_HEIGHT);
          x_r     <= x0_r;
          y_r     <= y0_r;
        end
        ST_FILL: begin
          if (fill_accept_s) begin
            if (row_end_s) begin
              x_r <= x0_r;
              y_r <= y_r + 10'd1;
            end else begin
              x_r <= x_r + 10'd1;
            end
          end
        end
        default: begin
          x_r <= x_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: each task drives one scenario and checks the
// write stream, done pulses and handshake against hand-computed values.
module tb_vga_rect_fill;

  logic        clk50M;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x0, cmd_y0, cmd_w, cmd_h;
  logic [7:0]  cmd_color;
  logic        cpu_write_enable;
  logic [17:0] cpu_write_addr;
  logic [7:0]  cpu_write_data;
  logic [17:0] write_addr;
  logic [7:0]  write_data;
  logic        write_enable;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  // Writes seen after an accept edge: cycle index k (accept edge is k=0).
  int          wr_k[$];
  logic [17:0] wr_a[$];
  logic [7:0]  wr_d[$];
  int          done_k[$];
  logic        rdy_q[$];

  vga_rect_fill dut (
    .clk50M(clk50M), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .cpu_write_enable(cpu_write_enable), .cpu_write_addr(cpu_write_addr),
    .cpu_write_data(cpu_write_data),
    .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
    .busy(busy), .done(done)
  );

  initial clk50M = 1'b0;
  always #10 clk50M = ~clk50M;

  task automatic send_cmd(input logic [9:0] x0, input logic [9:0] y0, input logic [9:0] w,
                          input logic [9:0] h, input logic [7:0] c, input bit hold);
    @(negedge clk50M);
    cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_color = c;
    cmd_valid = 1'b1;
    @(posedge clk50M);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic collect(input int n, input int cpu_k, input int drop_k);
    wr_k.delete(); wr_a.delete(); wr_d.delete(); done_k.delete(); rdy_q.delete();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk50M);
      #1;
      if (write_enable) begin
        wr_k.push_back(k); wr_a.push_back(write_addr); wr_d.push_back(write_data);
      end
      if (done) done_k.push_back(k);
      rdy_q.push_back(cmd_ready);
      if (k == cpu_k - 1) begin
        cpu_write_enable = 1'b1; cpu_write_addr = 18'd5000; cpu_write_data = 8'h55;
      end else if (k == cpu_k) begin
        cpu_write_enable = 1'b0;
      end
      if (k == drop_k) cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #5;
    n_cmp++;
    if ({write_enable, write_addr, write_data, done, busy} !== 29'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got we=%0b addr=%0d data=%0h done=%0b busy=%0b, expected all 0",
               write_enable, write_addr, write_data, done, busy);
    end
    @(negedge clk50M); @(negedge clk50M);
    rst = 1'b0;
    @(posedge clk50M); #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got cmd_ready=%0b busy=%0b, expected 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic_fill();
    logic [17:0] exp_a[6] = '{18'd10250, 18'd10251, 18'd10252, 18'd10762, 18'd10763, 18'd10764};
    send_cmd(10'd10, 10'd20, 10'd3, 10'd2, 8'hE0, 1'b0);
    n_cmp++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL basic_accept: got busy=%0b cmd_ready=%0b, expected 1/0", busy, cmd_ready);
    end
    collect(12, 0, 0);
    n_cmp++;
    if (wr_a.size() != 6) begin
      n_err++; $display("FAIL basic_count: got %0d writes, expected 6", wr_a.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < wr_a.size()) begin
        n_cmp++;
        if (wr_a[i] !== exp_a[i] || wr_d[i] !== 8'hE0 || wr_k[i] != 2 + i) begin
          n_err++;
          $display("FAIL basic_write%0d: got addr=%0d data=%0h k=%0d, expected addr=%0d data=e0 k=%0d",
                   i, wr_a[i], wr_d[i], wr_k[i], exp_a[i], 2 + i);
        end
      end
    end
    n_cmp++;
    if (done_k.size() != 1 || (done_k.size() == 1 && done_k[0] != 7)) begin
      n_err++; $display("FAIL basic_done: got %0d pulses (first k=%0d), expected 1 at k=7",
                        done_k.size(), (done_k.size() > 0) ? done_k[0] : -1);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_idle: got cmd_ready=%0b busy=%0b, expected 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_clip();
    send_cmd(10'd398, 10'd299, 10'd5, 10'd4, 8'h1C, 1'b0);
    collect(10, 0, 0);
    n_cmp++;
    if (wr_a.size() != 2) begin
      n_err++; $display("FAIL clip_count: got %0d writes, expected 2", wr_a.size());
    end else begin
      n_cmp++;
      if (wr_a[0] !== 18'd153486 || wr_a[1] !== 18'd153487 || wr_d[0] !== 8'h1C ||
          wr_d[1] !== 8'h1C || wr_k[0] != 2 || wr_k[1] != 3) begin
        n_err++;
        $display("FAIL clip_writes: got %0d/%0h@%0d %0d/%0h@%0d, expected 153486/1c@2 153487/1c@3",
                 wr_a[0], wr_d[0], wr_k[0], wr_a[1], wr_d[1], wr_k[1]);
      end
    end
    n_cmp++;
    if (done_k.size() != 1 || (done_k.size() == 1 && done_k[0] != 3)) begin
      n_err++; $display("FAIL clip_done: got %0d pulses, expected 1 at k=3", done_k.size());
    end
  endtask

  task automatic test_degenerate(input logic [9:0] x0, input logic [9:0] w, input string tag);
    send_cmd(x0, 10'd5, w, 10'd3, 8'hFF, 1'b0);
    collect(5, 0, 0);
    n_cmp++;
    if (wr_a.size() != 0) begin
      n_err++; $display("FAIL %s_writes: got %0d writes, expected 0", tag, wr_a.size());
    end
    n_cmp++;
    if (done_k.size() != 1 || (done_k.size() == 1 && done_k[0] != 1)) begin
      n_err++; $display("FAIL %s_done: got %0d pulses, expected 1 at k=1", tag, done_k.size());
    end
    n_cmp++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL %s_idle: got busy=%0b cmd_ready=%0b, expected 0/1", tag, busy, cmd_ready);
    end
  endtask

  task automatic test_cpu_priority();
    logic [17:0] exp_a[5] = '{18'd0, 18'd1, 18'd5000, 18'd2, 18'd3};
    logic [7:0]  exp_d[5] = '{8'h03, 8'h03, 8'h55, 8'h03, 8'h03};
    send_cmd(10'd0, 10'd0, 10'd4, 10'd1, 8'h03, 1'b0);
    collect(10, 4, 0);
    n_cmp++;
    if (wr_a.size() != 5) begin
      n_err++; $display("FAIL cpu_count: got %0d writes, expected 5", wr_a.size());
    end
    for (int i = 0; i < 5; i++) begin
      if (i < wr_a.size()) begin
        n_cmp++;
        if (wr_a[i] !== exp_a[i] || wr_d[i] !== exp_d[i] || wr_k[i] != 2 + i) begin
          n_err++;
          $display("FAIL cpu_write%0d: got addr=%0d data=%0h k=%0d, expected addr=%0d data=%0h k=%0d",
                   i, wr_a[i], wr_d[i], wr_k[i], exp_a[i], exp_d[i], 2 + i);
        end
      end
    end
    n_cmp++;
    if (done_k.size() != 1 || (done_k.size() == 1 && done_k[0] != 6)) begin
      n_err++; $display("FAIL cpu_done: got %0d pulses, expected 1 at k=6", done_k.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [17:0] exp_a[4] = '{18'd513, 18'd514, 18'd1025, 18'd1026};
    send_cmd(10'd0, 10'd0, 10'd10, 10'd10, 8'hAA, 1'b0);
    collect(5, 0, 0);
    n_cmp++;
    if (wr_a.size() != 4 || write_enable !== 1'b1) begin
      n_err++; $display("FAIL rst_prefill: got %0d writes we=%0b, expected 4 and 1", wr_a.size(), write_enable);
    end
    #5;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (write_enable !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_async: got we=%0b done=%0b busy=%0b, expected 0/0/0",
                        write_enable, done, busy);
    end
    @(negedge clk50M); @(negedge clk50M);
    rst = 1'b0;
    collect(20, 0, 0);
    n_cmp++;
    if (wr_a.size() != 0 || done_k.size() != 0 || cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_after: got %0d writes %0d done cmd_ready=%0b, expected 0/0/1",
                        wr_a.size(), done_k.size(), cmd_ready);
    end
    send_cmd(10'd1, 10'd1, 10'd2, 10'd2, 8'h5A, 1'b0);
    collect(8, 0, 0);
    n_cmp++;
    if (wr_a.size() != 4) begin
      n_err++; $display("FAIL rst_new_count: got %0d writes, expected 4", wr_a.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < wr_a.size()) begin
        n_cmp++;
        if (wr_a[i] !== exp_a[i] || wr_d[i] !== 8'h5A || wr_k[i] != 2 + i) begin
          n_err++;
          $display("FAIL rst_new_write%0d: got addr=%0d data=%0h k=%0d, expected addr=%0d data=5a k=%0d",
                   i, wr_a[i], wr_d[i], wr_k[i], exp_a[i], 2 + i);
        end
      end
    end
    n_cmp++;
    if (done_k.size() != 1 || (done_k.size() == 1 && done_k[0] != 5)) begin
      n_err++; $display("FAIL rst_new_done: got %0d pulses, expected 1 at k=5", done_k.size());
    end
  endtask

  task automatic test_back_to_back();
    send_cmd(10'd5, 10'd0, 10'd2, 10'd1, 8'h11, 1'b1);
    cmd_x0 = 10'd7; cmd_y0 = 10'd1; cmd_w = 10'd1; cmd_h = 10'd1; cmd_color = 8'h22;
    collect(12, 0, 5);
    n_cmp++;
    if (wr_a.size() != 3) begin
      n_err++; $display("FAIL b2b_count: got %0d writes, expected 3", wr_a.size());
    end else begin
      n_cmp++;
      if (wr_a[0] !== 18'd5 || wr_d[0] !== 8'h11 || wr_k[0] != 2 ||
          wr_a[1] !== 18'd6 || wr_d[1] !== 8'h11 || wr_k[1] != 3 ||
          wr_a[2] !== 18'd519 || wr_d[2] !== 8'h22 || wr_k[2] != 7) begin
        n_err++;
        $display("FAIL b2b_writes: got %0d/%0h@%0d %0d/%0h@%0d %0d/%0h@%0d, expected 5/11@2 6/11@3 519/22@7",
                 wr_a[0], wr_d[0], wr_k[0], wr_a[1], wr_d[1], wr_k[1], wr_a[2], wr_d[2], wr_k[2]);
      end
    end
    n_cmp++;
    if (done_k.size() != 2 || (done_k.size() == 2 && (done_k[0] != 3 || done_k[1] != 7))) begin
      n_err++; $display("FAIL b2b_done: got %0d pulses, expected 2 at k=3 and k=7", done_k.size());
    end
    n_cmp++;
    if (rdy_q[3] !== 1'b1 || rdy_q[4] !== 1'b0 || rdy_q[11] !== 1'b1) begin
      n_err++; $display("FAIL b2b_ready: got k4=%0b k5=%0b k12=%0b, expected 1/0/1",
                        rdy_q[3], rdy_q[4], rdy_q[11]);
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_x0 = 10'd0; cmd_y0 = 10'd0; cmd_w = 10'd0; cmd_h = 10'd0; cmd_color = 8'd0;
    cpu_write_enable = 1'b0; cpu_write_addr = 18'd0; cpu_write_data = 8'd0;
    test_reset();
    test_basic_fill();
    test_clip();
    test_degenerate(10'd3, 10'd0, "zero_w");
    test_degenerate(10'd400, 10'd4, "x_off");
    test_cpu_priority();
    test_reset_mid_fill();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
